// File: rtl/tcp_ack_tx_gen.sv
// Builds a 66-byte Eth/IPv4/TCP frame (timestamp option, no payload) from one
// descriptor and streams it as three 256-bit AXI4-Stream beats.
module tcp_ack_tx_gen #(
    parameter int          C_M_AXIS_DATA_WIDTH  = 256,
    parameter int          C_M_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0]  SRC_PORT_ONEHOT      = 8'h00,
    parameter logic [7:0]  IP_TTL               = 8'd64,
    parameter logic [15:0] TCP_WINDOW           = 16'hFFFF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [7:0]                        req_flags,
    input  logic [31:0]                       req_seq,
    input  logic [31:0]                       req_ack,
    input  logic [31:0]                       req_ts_val,
    input  logic [31:0]                       req_ts_ecr,
    input  logic [47:0]                       req_dst_mac,
    input  logic [47:0]                       req_src_mac,
    input  logic [31:0]                       req_src_ip,
    input  logic [31:0]                       req_dst_ip,
    input  logic [15:0]                       req_src_l4,
    input  logic [15:0]                       req_dst_l4,
    input  logic [7:0]                        req_dst_port,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    typedef enum logic [2:0] {S_IDLE, S_CSUM_A, S_CSUM_B, S_W0, S_W1, S_W2} state_t;

    state_t      state_q, state_d;
    logic [15:0] ip_id_q;
    logic [7:0]  flags_q, dport_q;
    logic [31:0] seq_q, ack_q, tsv_q, tse_q, sip_q, dip_q;
    logic [47:0] dmac_q, smac_q;
    logic [15:0] sl4_q, dl4_q;
    logic [19:0] ip_sum_q, tcp_sum_q, ip_sum_d, tcp_sum_d;
    logic [15:0] ip_csum_q, tcp_csum_q;
    logic [16:0] ip_f1, tcp_f1;
    logic [15:0] ip_f2, tcp_f2;
    logic [15:0] ip_words [10];
    logic [15:0] tcp_words [22];

    logic [527:0] frame_w;
    logic [255:0] w0_data, w1_data, w2_data;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_w;

    always_comb begin
        ip_words[0] = 16'h4500;
        ip_words[1] = 16'd52;
        ip_words[2] = ip_id_q;
        ip_words[3] = 16'h4000;
        ip_words[4] = {IP_TTL, 8'h06};
        ip_words[5] = 16'h0000;
        ip_words[6] = sip_q[31:16];
        ip_words[7] = sip_q[15:0];
        ip_words[8] = dip_q[31:16];
        ip_words[9] = dip_q[15:0];
        // Pseudo-header first, then TCP header with a zero checksum, then the option.
        tcp_words[0]  = sip_q[31:16];
        tcp_words[1]  = sip_q[15:0];
        tcp_words[2]  = dip_q[31:16];
        tcp_words[3]  = dip_q[15:0];
        tcp_words[4]  = 16'h0006;
        tcp_words[5]  = 16'd32;
        tcp_words[6]  = sl4_q;
        tcp_words[7]  = dl4_q;
        tcp_words[8]  = seq_q[31:16];
        tcp_words[9]  = seq_q[15:0];
        tcp_words[10] = ack_q[31:16];
        tcp_words[11] = ack_q[15:0];
        tcp_words[12] = {8'h80, flags_q};
        tcp_words[13] = TCP_WINDOW;
        tcp_words[14] = 16'h0000;
        tcp_words[15] = 16'h0000;
        tcp_words[16] = 16'h0101;
        tcp_words[17] = 16'h080A;
        tcp_words[18] = tsv_q[31:16];
        tcp_words[19] = tsv_q[15:0];
        tcp_words[20] = tse_q[31:16];
        tcp_words[21] = tse_q[15:0];
        ip_sum_d  = '0;
        tcp_sum_d = '0;
        for (int i = 0; i < 10; i++) ip_sum_d = ip_sum_d + {4'b0, ip_words[i]};
        for (int i = 0; i < 22; i++) tcp_sum_d = tcp_sum_d + {4'b0, tcp_words[i]};
    end

    assign ip_f1  = {1'b0, ip_sum_q[15:0]} + {13'b0, ip_sum_q[19:16]};
    assign ip_f2  = ip_f1[15:0] + {15'b0, ip_f1[16]};
    assign tcp_f1 = {1'b0, tcp_sum_q[15:0]} + {13'b0, tcp_sum_q[19:16]};
    assign tcp_f2 = tcp_f1[15:0] + {15'b0, tcp_f1[16]};

    assign frame_w = {dmac_q, smac_q, 16'h0800,
                      8'h45, 8'h00, 16'd52, ip_id_q, 16'h4000, IP_TTL, 8'h06, ip_csum_q, sip_q, dip_q,
                      sl4_q, dl4_q, seq_q, ack_q, 8'h80, flags_q, TCP_WINDOW, tcp_csum_q, 16'h0000,
                      32'h0101080A, tsv_q, tse_q};

    // Wire byte b sits in the lane (b mod 32) of beat (b / 32).
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_pack
            assign w0_data[8*gi +: 8] = frame_w[527-8*gi -: 8];
            assign w1_data[8*gi +: 8] = frame_w[527-8*(gi+32) -: 8];
        end
    endgenerate
    assign w2_data = {240'b0, frame_w[7:0], frame_w[15:8]};
    assign tuser_w = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, dport_q, SRC_PORT_ONEHOT, 16'd66};

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = !reset;
                if (req_valid) state_d = S_CSUM_A;
            end
            S_CSUM_A: state_d = S_CSUM_B;
            S_CSUM_B: state_d = S_W0;
            S_W0: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w0_data;
                m_axis_tkeep  = '1;
                m_axis_tuser  = tuser_w;
                if (m_axis_tready) state_d = S_W1;
            end
            S_W1: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w1_data;
                m_axis_tkeep  = '1;
                m_axis_tuser  = tuser_w;
                if (m_axis_tready) state_d = S_W2;
            end
            S_W2: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = w2_data;
                m_axis_tkeep  = 32'h00000003;
                m_axis_tuser  = tuser_w;
                if (m_axis_tready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ip_id_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (state_q == S_W2 && m_axis_tready) ip_id_q <= ip_id_q + 16'h0001;
        end
    end

    // Datapath registers need no reset: outputs are gated by state.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && req_valid) begin
            flags_q <= req_flags;
            seq_q   <= req_seq;
            ack_q   <= req_ack;
            tsv_q   <= req_ts_val;
            tse_q   <= req_ts_ecr;
            dmac_q  <= req_dst_mac;
            smac_q  <= req_src_mac;
            sip_q   <= req_src_ip;
            dip_q   <= req_dst_ip;
            sl4_q   <= req_src_l4;
            dl4_q   <= req_dst_l4;
            dport_q <= req_dst_port;
        end
        if (state_q == S_CSUM_A) begin
            ip_sum_q  <= ip_sum_d;
            tcp_sum_q <= tcp_sum_d;
        end
        if (state_q == S_CSUM_B) begin
            ip_csum_q  <= ~ip_f2;
            tcp_csum_q <= ~tcp_f2;
        end
    end

endmodule

// File: tb/tb_tcp_ack_tx_gen.sv
// Scoreboard bench for tcp_ack_tx_gen: the driver pushes expected beats on
// acceptance, the monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_tcp_ack_tx_gen;

    localparam logic [7:0] SRC_OH = 8'h01;

    typedef struct packed {
        logic [7:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [31:0] tsv;
        logic [31:0] tse;
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sl4;
        logic [15:0] dl4;
        logic [7:0]  dport;
    } desc_t;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [7:0]  req_flags = '0;
    logic [31:0] req_seq = '0, req_ack = '0, req_ts_val = '0, req_ts_ecr = '0;
    logic [47:0] req_dst_mac = '0, req_src_mac = '0;
    logic [31:0] req_src_ip = '0, req_dst_ip = '0;
    logic [15:0] req_src_l4 = '0, req_dst_l4 = '0;
    logic [7:0]  req_dst_port = '0;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic m_axis_tvalid, m_axis_tlast;
    logic m_axis_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int frames_done = 0;
    int tr_mode = 0;
    logic rst_at_edge = 1'b0;
    logic mon_busy = 1'b0;
    logic [15:0] exp_id = 16'h0000;
    logic [15:0] last_ip_csum = '0, last_tcp_csum = '0;
    beat_t sb [$];

    always #5 clk = ~clk;

    tcp_ack_tx_gen #(
        .C_M_AXIS_DATA_WIDTH(256), .C_M_AXIS_TUSER_WIDTH(128),
        .SRC_PORT_ONEHOT(SRC_OH), .IP_TTL(8'd64), .TCP_WINDOW(16'hFFFF)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_flags(req_flags), .req_seq(req_seq), .req_ack(req_ack),
        .req_ts_val(req_ts_val), .req_ts_ecr(req_ts_ecr),
        .req_dst_mac(req_dst_mac), .req_src_mac(req_src_mac),
        .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip),
        .req_src_l4(req_src_l4), .req_dst_l4(req_dst_l4), .req_dst_port(req_dst_port),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return ~s[15:0];
    endfunction

    function automatic desc_t mk(input logic [7:0] f, input logic [31:0] seq, input logic [31:0] ack,
                                 input logic [31:0] tsv, input logic [31:0] tse,
                                 input logic [15:0] sl4, input logic [7:0] dport);
        desc_t d;
        d.flags = f; d.seq = seq; d.ack = ack; d.tsv = tsv; d.tse = tse;
        d.dmac = 48'h001122334455; d.smac = 48'h0A0B0C0D0E0F;
        d.sip = 32'h0A000001; d.dip = 32'h0A000002;
        d.sl4 = sl4; d.dl4 = 16'h0050; d.dport = dport;
        return d;
    endfunction

    task automatic push_frame(input desc_t d, input logic [15:0] id);
        logic [7:0] b [0:95];
        logic [31:0] s;
        logic [15:0] c;
        beat_t bt;
        for (int i = 0; i < 96; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = d.dmac[47-8*i -: 8];
            b[6+i]   = d.smac[47-8*i -: 8];
        end
        b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'd52;
        b[18] = id[15:8]; b[19] = id[7:0]; b[20] = 8'h40; b[22] = 8'd64; b[23] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            b[26+i] = d.sip[31-8*i -: 8];
            b[30+i] = d.dip[31-8*i -: 8];
            b[38+i] = d.seq[31-8*i -: 8];
            b[42+i] = d.ack[31-8*i -: 8];
            b[58+i] = d.tsv[31-8*i -: 8];
            b[62+i] = d.tse[31-8*i -: 8];
        end
        b[34] = d.sl4[15:8]; b[35] = d.sl4[7:0]; b[36] = d.dl4[15:8]; b[37] = d.dl4[7:0];
        b[46] = 8'h80; b[47] = d.flags; b[48] = 8'hFF; b[49] = 8'hFF;
        b[54] = 8'h01; b[55] = 8'h01; b[56] = 8'h08; b[57] = 8'h0A;
        s = 32'h0;
        for (int i = 14; i < 34; i += 2) s += {16'h0, b[i], b[i+1]};
        c = fold(s); b[24] = c[15:8]; b[25] = c[7:0];
        s = {16'h0, d.sip[31:16]} + {16'h0, d.sip[15:0]} + {16'h0, d.dip[31:16]} + {16'h0, d.dip[15:0]}
            + 32'd6 + 32'd32;
        for (int i = 34; i < 66; i += 2) s += {16'h0, b[i], b[i+1]};
        c = fold(s); b[50] = c[15:8]; b[51] = c[7:0];
        for (int w = 0; w < 3; w++) begin
            bt.data = '0;
            for (int k = 0; k < 32; k++) bt.data[8*k +: 8] = b[32*w+k];
            bt.keep = (w < 2) ? 32'hFFFFFFFF : 32'h00000003;
            bt.user = {96'h0, d.dport, SRC_OH, 16'd66};
            bt.last = (w == 2);
            sb.push_back(bt);
        end
    endtask

    task automatic send(input desc_t d, input bit hold_after);
        logic got, rdy;
        req_flags = d.flags; req_seq = d.seq; req_ack = d.ack;
        req_ts_val = d.tsv; req_ts_ecr = d.tse;
        req_dst_mac = d.dmac; req_src_mac = d.smac;
        req_src_ip = d.sip; req_dst_ip = d.dip;
        req_src_l4 = d.sl4; req_dst_l4 = d.dl4; req_dst_port = d.dport;
        req_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            rdy = req_ready && !reset;
            @(posedge clk);
            if (rdy) begin
                got = 1'b1;
                push_frame(d, exp_id);
                exp_id = exp_id + 16'h1;
            end
        end
        #1;
        if (!hold_after) req_valid = 1'b0;
        check("accept_timeout", 256'(got), 256'(1));
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            if (sb.size() == 0 && !mon_busy) break;
            @(posedge clk);
        end
        check("drain_timeout", 256'(sb.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin : tready_drv
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    initial begin : rst_sampler
        forever begin
            @(posedge clk);
            rst_at_edge = reset;
        end
    end

    initial begin : monitor
        beat_t e;
        logic [255:0] hd;
        logic [31:0] hk;
        logic [127:0] hu;
        logic hl, hold;
        int nb;
        logic [7:0] fr [0:95];
        logic [31:0] s;
        hold = 1'b0; nb = 0; hd = '0; hk = '0; hu = '0; hl = 1'b0;
        for (int i = 0; i < 96; i++) fr[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_req_ready", 256'(req_ready), 256'(0));
                if (rst_at_edge) begin
                    check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
                    check("rst_tlast", 256'(m_axis_tlast), 256'(0));
                    check("rst_tdata", m_axis_tdata, 256'(0));
                    check("rst_tkeep_tuser", 256'({m_axis_tkeep, m_axis_tuser}), 256'(0));
                end
                hold = 1'b0; mon_busy = 1'b0; nb = 0;
                sb.delete();
            end else begin
                check("req_ready", 256'(req_ready), 256'(!mon_busy));
                if (hold) begin
                    check("hold_tdata", m_axis_tdata, hd);
                    check("hold_ctrl", 256'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser}),
                          256'({1'b1, hl, hk, hu}));
                end
                hold = m_axis_tvalid && !m_axis_tready;
                hd = m_axis_tdata; hk = m_axis_tkeep; hu = m_axis_tuser; hl = m_axis_tlast;
                if (req_valid && req_ready) mon_busy = 1'b1;
                if (m_axis_tvalid && m_axis_tready) begin
                    check("sb_nonempty", 256'(sb.size() > 0), 256'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("tdata", m_axis_tdata, e.data);
                        check("tkeep", 256'(m_axis_tkeep), 256'(e.keep));
                        check("tuser", 256'(m_axis_tuser), 256'(e.user));
                        check("tlast", 256'(m_axis_tlast), 256'(e.last));
                    end
                    if (nb < 3)
                        for (int k = 0; k < 32; k++)
                            if (m_axis_tkeep[k]) fr[nb*32+k] = m_axis_tdata[8*k +: 8];
                    nb++;
                    if (m_axis_tlast) begin
                        check("beat_count", 256'(nb), 256'(3));
                        s = 32'h0;
                        for (int i = 14; i < 34; i += 2) s += {16'h0, fr[i], fr[i+1]};
                        check("ip_csum_valid", 256'(fold(s)), 256'(0));
                        s = 32'd6 + 32'd32;
                        for (int i = 26; i < 34; i += 2) s += {16'h0, fr[i], fr[i+1]};
                        for (int i = 34; i < 66; i += 2) s += {16'h0, fr[i], fr[i+1]};
                        check("tcp_csum_valid", 256'(fold(s)), 256'(0));
                        last_ip_csum  = {fr[24], fr[25]};
                        last_tcp_csum = {fr[50], fr[51]};
                        $display("frame %0d flags=%h ip_id=%h ip_csum=%h tcp_csum=%h",
                                 frames_done, fr[47], {fr[18], fr[19]}, last_ip_csum, last_tcp_csum);
                        frames_done++;
                        nb = 0;
                        mon_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic got;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reference ACK: checksums computed by hand for this descriptor.
        send(mk(8'h10, 32'h00000001, 32'h12345679, 32'd1, 32'd2, 16'h1234, 8'h04), 1'b0);
        drain();
        check("ip_csum_ref", 256'(last_ip_csum), 256'(16'h26C2));
        check("tcp_csum_ref", 256'(last_tcp_csum), 256'(16'hE785));

        // Backpressure toggling every cycle.
        tr_mode = 1;
        send(mk(8'h18, 32'hDEADBEEF, 32'h01020304, 32'hCAFEF00D, 32'h0BADBEEF, 16'hC001, 8'h10), 1'b0);
        drain();
        tr_mode = 0;

        // Back-to-back FIN/ACK then ACK with req_valid held.
        send(mk(8'h11, 32'h00000100, 32'h00000200, 32'h11111111, 32'h22222222, 16'h8000, 8'h02), 1'b1);
        send(mk(8'h10, 32'h00000101, 32'h00000201, 32'h33333333, 32'h44444444, 16'h8000, 8'h02), 1'b0);
        drain();

        // Reset in W1 with tready low abandons the frame.
        tr_mode = 2;
        send(mk(8'h10, 32'h55555555, 32'h66666666, 32'h7, 32'h8, 16'h4321, 8'h01), 1'b0);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (m_axis_tvalid) got = 1'b1;
        end
        check("w0_seen", 256'(got), 256'(1));
        tr_mode = 0;
        @(negedge clk);
        tr_mode = 2;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        exp_id = 16'h0000;
        tr_mode = 0;
        send(mk(8'h10, 32'h00000001, 32'h12345679, 32'd1, 32'd2, 16'h1234, 8'h04), 1'b0);
        drain();
        check("ip_csum_after_rst", 256'(last_ip_csum), 256'(16'h26C2));

        // ip_id wrap FFFF -> 0000.
        force dut.ip_id_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.ip_id_q;
        exp_id = 16'hFFFF;
        send(mk(8'h10, 32'h0000A000, 32'h0000B000, 32'h9, 32'hA, 16'h2222, 8'h08), 1'b1);
        send(mk(8'h11, 32'h0000A001, 32'h0000B001, 32'hB, 32'hC, 16'h2222, 8'h08), 1'b0);
        drain();

        check("frames_done", 256'(frames_done), 256'(7));
        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
